// File: rtl/stopwatch_pkg.sv
// Shared definitions for the centisecond stopwatch: FSM encodings,
// seven-segment codes (active-low {dp,g,f,e,d,c,b,a}) and BCD digit limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_e;

    // Segment codes with the decimal point off.
    localparam logic [7:0] Seg0     = 8'hC0;
    localparam logic [7:0] Seg1     = 8'hF9;
    localparam logic [7:0] Seg2     = 8'hA4;
    localparam logic [7:0] Seg3     = 8'hB0;
    localparam logic [7:0] Seg4     = 8'h99;
    localparam logic [7:0] Seg5     = 8'h92;
    localparam logic [7:0] Seg6     = 8'h82;
    localparam logic [7:0] Seg7     = 8'hF8;
    localparam logic [7:0] Seg8     = 8'h80;
    localparam logic [7:0] Seg9     = 8'h90;
    localparam logic [7:0] SegBlank = 8'hFF;

    // Terminal values of the BCD digits.
    localparam logic [3:0] DigMax     = 4'd9;
    localparam logic [3:0] SecTensMax = 4'd5;

endpackage

// File: rtl/stopwatch_if.sv
// Front-panel / display bundle between the board top and the stopwatch core.
interface stopwatch_if;

    logic        tick;
    logic        start_stop;
    logic        clear;
    logic [15:0] digits;
    logic        running;
    logic        wrap;
    logic [3:0]  an;
    logic [7:0]  seg;

    // Board side: drives tick and buttons, observes time and display.
    modport master (
        output tick, start_stop, clear,
        input  digits, running, wrap, an, seg
    );

    // Stopwatch core side.
    modport slave (
        input  tick, start_stop, clear,
        output digits, running, wrap, an, seg
    );

endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low seven-segment decoder; non-BCD values blank the digit.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_dp_en,
    output logic [7:0] o_seg
);

    // Segment lookup, then force the decimal point on when requested.
    always_comb begin
        o_seg = SegBlank;
        case (i_bcd)
            4'd0:    o_seg = Seg0;
            4'd1:    o_seg = Seg1;
            4'd2:    o_seg = Seg2;
            4'd3:    o_seg = Seg3;
            4'd4:    o_seg = Seg4;
            4'd5:    o_seg = Seg5;
            4'd6:    o_seg = Seg6;
            4'd7:    o_seg = Seg7;
            4'd8:    o_seg = Seg8;
            4'd9:    o_seg = Seg9;
            default: o_seg = SegBlank;
        endcase
        if (i_dp_en) begin
            o_seg[7] = 1'b0;
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: run/pause/clear control, SS.cc BCD count and
// four-digit multiplexed seven-segment scan.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    stopwatch_if.slave   bus
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);

    logic            r_ss_q;
    logic            r_clr_q;
    sw_state_e       r_state;
    sw_state_e       w_state_d;
    logic [15:0]     r_digits;
    logic [15:0]     w_digits_d;
    logic            r_wrap;
    logic            w_wrap_d;
    logic [CntW-1:0] r_scan_cnt;
    logic [1:0]      r_idx;

    logic            w_ss_rise;
    logic            w_clr_rise;
    logic            w_count_en;
    logic [3:0]      w_bcd;
    logic            w_dp_en;

    assign w_ss_rise  = bus.start_stop & ~r_ss_q;
    assign w_clr_rise = bus.clear & ~r_clr_q;
    // A clear in the same cycle drops the tick.
    assign w_count_en = (r_state == StRun) && bus.tick && !w_clr_rise;

    // Button edge-detect registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ss_q  <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_ss_q  <= bus.start_stop;
            r_clr_q <= bus.clear;
        end
    end

    // Control FSM state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Control FSM next state; clear beats start/stop.
    always_comb begin
        w_state_d = r_state;
        if (w_clr_rise) begin
            w_state_d = StIdle;
        end else if (w_ss_rise) begin
            case (r_state)
                StIdle:  w_state_d = StRun;
                StRun:   w_state_d = StPause;
                StPause: w_state_d = StRun;
                default: w_state_d = StIdle;
            endcase
        end
    end

    // BCD ripple counter next value and rollover flag.
    always_comb begin
        w_digits_d = r_digits;
        w_wrap_d   = 1'b0;
        if (w_clr_rise) begin
            w_digits_d = 16'h0000;
        end else if (w_count_en) begin
            if (r_digits[3:0] != DigMax) begin
                w_digits_d[3:0] = r_digits[3:0] + 4'd1;
            end else begin
                w_digits_d[3:0] = 4'd0;
                if (r_digits[7:4] != DigMax) begin
                    w_digits_d[7:4] = r_digits[7:4] + 4'd1;
                end else begin
                    w_digits_d[7:4] = 4'd0;
                    if (r_digits[11:8] != DigMax) begin
                        w_digits_d[11:8] = r_digits[11:8] + 4'd1;
                    end else begin
                        w_digits_d[11:8] = 4'd0;
                        if (r_digits[15:12] != SecTensMax) begin
                            w_digits_d[15:12] = r_digits[15:12] + 4'd1;
                        end else begin
                            w_digits_d[15:12] = 4'd0;
                            w_wrap_d          = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Time count and registered wrap pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_digits <= 16'h0000;
            r_wrap   <= 1'b0;
        end else begin
            r_digits <= w_digits_d;
            r_wrap   <= w_wrap_d;
        end
    end

    // Display scan: hold each digit SCAN_DIV cycles, then step to the next.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == ScanLast) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_bcd   = r_digits[4*r_idx +: 4];
    // Decimal point separates seconds from centiseconds.
    assign w_dp_en = (r_idx == 2'd2);

    seg7_decode u_seg7_decode (
        .i_bcd   (w_bcd),
        .i_dp_en (w_dp_en),
        .o_seg   (bus.seg)
    );

    assign bus.an      = ~(4'b0001 << r_idx);
    assign bus.digits  = r_digits;
    assign bus.running = (r_state == StRun);
    assign bus.wrap    = r_wrap;

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Centisecond stopwatch that consumes the 100 Hz tick from the board clock divider and drives the 4-digit seven-segment display in SS.cc format (00.00–59.99). It sits directly downstream of the divider. It owns the run/pause/clear control from the two front-panel buttons, the BCD time count, and the display scan multiplexer.

## Interface
- `SCAN_DIV`, default 100000: CLK cycles per displayed digit. At 100 MHz this gives 1 kHz per digit.
- `CLK`, in, 1: board clock; all logic is on its rising edge.
- `rst_n`, in, 1: synchronous reset, active-low.
- `tick`, in, 1: one-CLK-cycle pulse at 100 Hz, synchronous to `CLK`.
- `start_stop`, in, 1: debounced button level; active on its rising edge.
- `clear`, in, 1: debounced button level; active on its rising edge.
- `digits`, out, 16: BCD time as {sec_tens, sec_units, cs_tens, cs_units}.
- `running`, out, 1: high in the RUN state.
- `wrap`, out, 1: one-cycle pulse when the count rolls 59.99→00.00.
- `an`, out, 4: active-low digit enables; `an[0]` selects cs_units.
- `seg`, out, 8: active-low {dp,g,f,e,d,c,b,a}.

## Operation
- Edge detect: `start_stop` and `clear` are each registered once.
  - `ss_rise` = `start_stop` & ~`ss_q`.
  - `clr_rise` = `clear` & ~`clr_q`.
  - Both `_q` registers reset to 0.
- States: IDLE (count is zero, stopped), RUN, PAUSE.
- Transitions:
  - IDLE --`ss_rise`--> RUN.
  - RUN --`ss_rise`--> PAUSE.
  - PAUSE --`ss_rise`--> RUN.
  - Any state --`clr_rise`--> IDLE, with digits zeroed.
  - `clr_rise` has priority over `ss_rise` in the same cycle.
- Counting: happens only while the current state is RUN and `tick`=1. It is a four-digit BCD ripple:
  - cs_units 0–9, cs_tens 0–9, sec_units 0–9, sec_tens 0–5.
  - Each digit carries at its terminal value.
- Wrap: a tick at 59.99 produces 00.00 and asserts `wrap` for exactly one cycle; the state stays RUN.
- Simultaneous events:
  - `tick` with `clr_rise`: the clear wins and the tick is dropped.
  - `tick` in the cycle of `ss_rise` from IDLE or PAUSE: not counted, because the state is not yet RUN.
  - `tick` in the cycle of `ss_rise` from RUN: counted.
- Scan:
  - `scan_cnt` counts 0..SCAN_DIV-1.
  - At terminal count it returns to 0 and the 2-bit `idx` advances 0→1→2→3→0.
  - Scanning runs in every state.
- Display:
  - `an` = ~(1<<`idx`).
  - `seg` = seven-segment code of `digits[4*idx +: 4]`.
  - dp (`seg[7]`=0) is lit only when `idx`=2 (after sec_units).
  - BCD codes with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).

## Timing
- Reset (`rst_n`=0 at a CLK edge) sets:
  - state to IDLE, `digits` = 16'h0000, `running` = 0, `wrap` = 0;
  - `scan_cnt` = 0, `idx` = 0, `an` = 4'b1110, `seg` = 8'hC0.
- Reset mid-count or mid-scan discards everything; there is no partial state.
- Button latency: if `start_stop` is first sampled high at edge k, `running` changes at edge k+1. `clear` behaves the same way for `digits`.
- Holding a button produces exactly one event.
- A `tick` sampled at edge k while in RUN updates `digits` at edge k+1.
- `wrap` is registered and is high for the single cycle following the rollover update.
- `an`/`seg` are a combinational decode of the registered `idx` and `digits`. Each digit is shown for exactly SCAN_DIV cycles.

## Structure
- Shared package/header `stopwatch_pkg` holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2);
  - the ten segment constants;
  - digit limits (9, 5).
- Sub-module `seg7_decode`: 4-bit BCD plus dp-enable in, 8-bit active-low segment out. Values 10–15 decode to 8'hFF (blank).
- Control FSM, BCD counter and scan counter stay in `stopwatch_core`.

## Test plan
Run the bench with SCAN_DIV=4 and drive `tick` manually.
- Reset: `rst_n`=0 for 2 cycles → `digits`=0000, `running`=0, `an`=1110, `seg`=C0.
- Start then 123 ticks: press `start_stop`, then issue 123 ticks → `digits`=16'h0123 and `running`=1.
- Button handling:
  - Hold `start_stop` high for 10 cycles → a single transition only.
  - A second press → PAUSE; subsequent ticks leave `digits` unchanged.
- Wrap: preload to 59.99 via 5999 ticks, then 1 more tick → `digits`=0000, `wrap` high for 1 cycle, `running` stays 1.
- Clear priority:
  - `clear` and `start_stop` rise together in RUN with `tick`=1 → IDLE, `digits`=0000, `running`=0.
  - Reset asserted mid-count → all outputs at their reset values.
- Scan at `digits`=16'h1234:
  - `an` steps 1110→1101→1011→0111, each held for 4 cycles.
  - `seg` = 99, B0, A4 with dp → 24, then F9.
